// File: rtl/alu_pc_unit.sv
// 8-bit combinational ALU with N/V/Z/C flags, plus a 16-bit program counter
// with load-over-increment priority and asynchronous reset.
module alu_pc_unit #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alu_a,
    input  logic [7:0]  alu_b,
    input  logic [4:0]  mode,
    input  logic        carry_in,
    output logic [7:0]  alu_out,
    output logic        carry_out,
    output logic        overflow,
    output logic        zero,
    output logic        sign,
    input  logic        pc_ld,
    input  logic        pc_inc,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out
);

    localparam int DATA_W = 8;

    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SUB    = 5'b00001,
        OP_AND    = 5'b00010,
        OP_OR     = 5'b00011,
        OP_EOR    = 5'b00100,
        OP_ASL    = 5'b00101,
        OP_LSR    = 5'b00110,
        OP_ROL    = 5'b00111,
        OP_ROR    = 5'b01000,
        OP_INC    = 5'b01001,
        OP_DEC    = 5'b01010,
        OP_CMP    = 5'b01011,
        OP_PASS_A = 5'b01100,
        OP_PASS_B = 5'b01101,
        OP_BIT    = 5'b01110
    } op_t;

    typedef struct packed {
        logic              v;
        logic              c;
        logic [DATA_W-1:0] sum;
    } adc_t;

    // Binary add-with-carry; SUB and CMP reuse it with an inverted operand so
    // that carry reads as "no borrow" and overflow follows the operand signs.
    function automatic adc_t adc(input logic [DATA_W-1:0] x,
                                 input logic [DATA_W-1:0] y,
                                 input logic              ci);
        adc_t             r;
        logic [DATA_W:0]  full;
        full  = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, ci};
        r.sum = full[DATA_W-1:0];
        r.c   = full[DATA_W];
        r.v   = (x[DATA_W-1] == y[DATA_W-1]) && (r.sum[DATA_W-1] != x[DATA_W-1]);
        return r;
    endfunction

    adc_t              add_res;
    logic [DATA_W-1:0] res;
    logic              res_c;
    logic              res_v;
    logic              bit_op;

    always_comb begin
        add_res = '0;
        res     = '0;
        res_c   = carry_in;
        res_v   = 1'b0;
        bit_op  = 1'b0;
        case (mode)
            OP_ADD: begin
                add_res = adc(alu_a, alu_b, carry_in);
                res     = add_res.sum;
                res_c   = add_res.c;
                res_v   = add_res.v;
            end
            OP_SUB: begin
                add_res = adc(alu_a, ~alu_b, carry_in);
                res     = add_res.sum;
                res_c   = add_res.c;
                res_v   = add_res.v;
            end
            OP_AND:    res = alu_a & alu_b;
            OP_OR:     res = alu_a | alu_b;
            OP_EOR:    res = alu_a ^ alu_b;
            OP_ASL: begin
                res   = {alu_a[DATA_W-2:0], 1'b0};
                res_c = alu_a[DATA_W-1];
            end
            OP_LSR: begin
                res   = {1'b0, alu_a[DATA_W-1:1]};
                res_c = alu_a[0];
            end
            OP_ROL: begin
                res   = {alu_a[DATA_W-2:0], carry_in};
                res_c = alu_a[DATA_W-1];
            end
            OP_ROR: begin
                res   = {carry_in, alu_a[DATA_W-1:1]};
                res_c = alu_a[0];
            end
            OP_INC:    res = alu_a + 8'd1;
            OP_DEC:    res = alu_a - 8'd1;
            OP_CMP: begin
                // Carry-in forced to 1 so the compare is a true a-b regardless of cin
                add_res = adc(alu_a, ~alu_b, 1'b1);
                res     = add_res.sum;
                res_c   = add_res.c;
            end
            OP_PASS_A: res = alu_a;
            OP_PASS_B: res = alu_b;
            OP_BIT: begin
                res    = alu_a & alu_b;
                res_v  = alu_b[DATA_W-2];
                bit_op = 1'b1;
            end
            default:   res = '0;
        endcase
    end

    assign alu_out   = res;
    assign carry_out = res_c;
    assign overflow  = res_v;
    assign zero      = (res == '0);
    assign sign      = bit_op ? alu_b[DATA_W-1] : res[DATA_W-1];

    // Program counter: load wins over increment; increment wraps silently
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_out <= PC_RESET;
        end else if (pc_ld) begin
            pc_out <= pc_in;
        end else if (pc_inc) begin
            pc_out <= pc_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_pc_unit.sv
// Self-checking bench for alu_pc_unit: directed and randomized ALU vectors
// against an integer-arithmetic model, plus PC sequencing and async reset.
module tb_alu_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [4:0]  mode;
    logic        carry_in;
    logic [7:0]  alu_out;
    logic        carry_out;
    logic        overflow;
    logic        zero;
    logic        sign;
    logic        pc_ld;
    logic        pc_inc;
    logic [15:0] pc_in;
    logic [15:0] pc_out;

    int passed = 0;
    int total  = 0;

    alu_pc_unit dut (
        .clk       (clk),
        .rst       (rst),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign),
        .pc_ld     (pc_ld),
        .pc_inc    (pc_inc),
        .pc_in     (pc_in),
        .pc_out    (pc_out)
    );

    always #5 clk = ~clk;

    // Reference result packed as {out[7:0], C, V, Z, N}
    function automatic logic [11:0] alu_model(input int m, input int a, input int b, input int cin);
        int out, c, v, z, n, sa, sb, sr;
        bit is_bit;
        out = 0; c = cin; v = 0; is_bit = 0;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (m)
            0: begin out = a + b + cin; sr = sa + sb + cin;
                     c = (out > 255) ? 1 : 0; v = (sr > 127 || sr < -128) ? 1 : 0; out = out % 256; end
            1: begin out = a + (255 - b) + cin; sr = sa - sb - 1 + cin;
                     c = (out > 255) ? 1 : 0; v = (sr > 127 || sr < -128) ? 1 : 0; out = out % 256; end
            2: out = a & b;
            3: out = a | b;
            4: out = a ^ b;
            5: begin out = (a * 2) % 256; c = a / 128; end
            6: begin out = a / 2; c = a % 2; end
            7: begin out = (a * 2 + cin) % 256; c = a / 128; end
            8: begin out = a / 2 + 128 * cin; c = a % 2; end
            9: out = (a + 1) % 256;
            10: out = (a + 255) % 256;
            11: begin out = (a - b + 256) % 256; c = (a >= b) ? 1 : 0; end
            12: out = a;
            13: out = b;
            14: begin out = a & b; is_bit = 1; v = (b / 64) % 2; end
            default: out = 0;
        endcase
        z = (out == 0) ? 1 : 0;
        n = is_bit ? b / 128 : out / 128;
        return {out[7:0], c[0], v[0], z[0], n[0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; pc_ld = 1'b0; pc_inc = 1'b0; pc_in = 16'h0;
        alu_a = 8'h0; alu_b = 8'h0; mode = 5'h0; carry_in = 1'b0;
        #1;
        total++;
        if (pc_out !== 16'h0000)
            $display("FAIL reset_pc: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 16'h0000)
            $display("FAIL reset_hold: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  m;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        cin;
        logic [11:0] exp;
    } vec_t;

    task automatic test_alu_directed();
        vec_t vecs[11];
        logic [11:0] got;
        vecs[0]  = '{5'b00000, 8'h50, 8'h50, 1'b0, {8'hA0, 4'b0101}};
        vecs[1]  = '{5'b00000, 8'hFF, 8'h01, 1'b0, {8'h00, 4'b1010}};
        vecs[2]  = '{5'b00001, 8'h50, 8'hF0, 1'b1, {8'h60, 4'b0000}};
        vecs[3]  = '{5'b01011, 8'h10, 8'h10, 1'b0, {8'h00, 4'b1010}};
        vecs[4]  = '{5'b01011, 8'h0F, 8'h10, 1'b1, {8'hFF, 4'b0001}};
        vecs[5]  = '{5'b01000, 8'h01, 8'h00, 1'b1, {8'h80, 4'b1001}};
        vecs[6]  = '{5'b00101, 8'h80, 8'h00, 1'b0, {8'h00, 4'b1010}};
        vecs[7]  = '{5'b01110, 8'h0F, 8'hC0, 1'b0, {8'h00, 4'b0111}};
        vecs[8]  = '{5'b11111, 8'h5A, 8'hA5, 1'b1, {8'h00, 4'b1010}};
        vecs[9]  = '{5'b01001, 8'hFF, 8'h00, 1'b1, {8'h00, 4'b1010}};
        vecs[10] = '{5'b01010, 8'h00, 8'h00, 1'b0, {8'hFF, 4'b0001}};
        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].m; alu_a = vecs[i].a; alu_b = vecs[i].b; carry_in = vecs[i].cin;
            #1;
            got = {alu_out, carry_out, overflow, zero, sign};
            total++;
            if (got !== vecs[i].exp)
                $display("FAIL alu_directed[%0d] mode=%b a=%h b=%h cin=%b: got out=%h CVZN=%b expected out=%h CVZN=%b",
                         i, mode, alu_a, alu_b, carry_in, got[11:4], got[3:0], vecs[i].exp[11:4], vecs[i].exp[3:0]);
            else passed++;
        end
    endtask

    task automatic test_alu_random(input int count, input logic hold_rst);
        logic [11:0] got, exp;
        rst = hold_rst;
        for (int i = 0; i < count; i++) begin
            mode = 5'($urandom_range(0, 31));
            alu_a = 8'($urandom);
            alu_b = 8'($urandom);
            carry_in = 1'($urandom);
            #1;
            exp = alu_model(int'(mode), int'(alu_a), int'(alu_b), int'(carry_in));
            got = {alu_out, carry_out, overflow, zero, sign};
            total++;
            if (got !== exp)
                $display("FAIL alu_random rst=%b mode=%b a=%h b=%h cin=%b: got out=%h CVZN=%b expected out=%h CVZN=%b",
                         hold_rst, mode, alu_a, alu_b, carry_in, got[11:4], got[3:0], exp[11:4], exp[3:0]);
            else passed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pc_sequence();
        logic [15:0] exp;
        pc_ld = 1'b0; pc_inc = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (pc_out !== 16'h0003) $display("FAIL pc_inc3: pc_out=%h expected=%h", pc_out, 16'h0003);
        else passed++;
        @(negedge clk); pc_ld = 1'b1; pc_inc = 1'b1; pc_in = 16'hFFFF;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 16'hFFFF) $display("FAIL pc_ld_priority: pc_out=%h expected=%h", pc_out, 16'hFFFF);
        else passed++;
        @(negedge clk); pc_ld = 1'b0; pc_inc = 1'b1;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 16'h0000) $display("FAIL pc_wrap: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        @(negedge clk); pc_ld = 1'b0; pc_inc = 1'b0; pc_in = 16'hBEEF;
        exp = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc_out !== exp) $display("FAIL pc_hold: pc_out=%h expected=%h", pc_out, exp);
        else passed++;
    endtask

    task automatic test_pc_random(input int count);
        int model_pc;
        model_pc = int'(pc_out);
        for (int i = 0; i < count; i++) begin
            @(negedge clk);
            pc_ld  = ($urandom_range(0, 3) == 0);
            pc_inc = 1'($urandom);
            pc_in  = 16'($urandom);
            if (pc_ld) model_pc = int'(pc_in);
            else if (pc_inc) model_pc = (model_pc + 1) % 65536;
            @(posedge clk); #1;
            total++;
            if (pc_out !== model_pc[15:0])
                $display("FAIL pc_random[%0d] ld=%b inc=%b: pc_out=%h expected=%h",
                         i, pc_ld, pc_inc, pc_out, model_pc[15:0]);
            else passed++;
        end
    endtask

    task automatic test_pc_async_reset();
        @(negedge clk); pc_ld = 1'b1; pc_inc = 1'b0; pc_in = 16'h1234;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 16'h1234) $display("FAIL pc_load_1234: pc_out=%h expected=%h", pc_out, 16'h1234);
        else passed++;
        @(negedge clk); pc_ld = 1'b0; pc_inc = 1'b1;
        #2; rst = 1'b1;
        #1;
        total++;
        if (pc_out !== 16'h0000) $display("FAIL pc_async_rst: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (pc_out !== 16'h0000) $display("FAIL pc_rst_overrides_inc: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        @(negedge clk); rst = 1'b0;
        #1;
        total++;
        if (pc_out !== 16'h0000) $display("FAIL pc_rst_release_no_edge: pc_out=%h expected=%h", pc_out, 16'h0000);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (pc_out !== 16'h0001) $display("FAIL pc_first_inc_after_rst: pc_out=%h expected=%h", pc_out, 16'h0001);
        else passed++;
        @(negedge clk); pc_inc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random(300, 1'b0);
        test_alu_random(40, 1'b1);
        test_pc_sequence();
        test_pc_async_reset();
        test_pc_random(200);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_pc_unit.md
ALU_PC_UNIT -- requirements
Module: alu_pc_unit

Interface
REQ-001 SHALL have parameter PC_RESET, default 16'h0000, value loaded into pc_out on reset.
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port alu_a  input  8  ALU operand A (accumulator side).
REQ-005 SHALL have port alu_b  input  8  ALU operand B (memory/data side).
REQ-006 SHALL have port mode  input  5  ALU operation select.
REQ-007 SHALL have port carry_in  input  1  carry into ADD/SUB/ROL/ROR.
REQ-008 SHALL have port alu_out  output  8  ALU result.
REQ-009 SHALL have port carry_out  output  1  C flag.
REQ-010 SHALL have port overflow  output  1  V flag.
REQ-011 SHALL have port zero  output  1  Z flag.
REQ-012 SHALL have port sign  output  1  N flag.
REQ-013 SHALL have port pc_ld  input  1  load pc_in into PC.
REQ-014 SHALL have port pc_inc  input  1  increment PC.
REQ-015 SHALL have port pc_in  input  16  PC load value.
REQ-016 SHALL have port pc_out  output  16  registered program counter.

Function
REQ-017 ALU SHALL be purely combinational: outputs settle within the same cycle, zero latency, no state.
REQ-018 mode 00000 ADD SHALL give {C,out}=a+b+cin; V=(a7==b7)&&(out7!=a7).
REQ-019 mode 00001 SUB SHALL give {C,out}=a+~b+cin (C=1 means no borrow); V=(a7!=b7)&&(out7!=a7).
REQ-020 modes 00010 AND, 00011 OR, 00100 EOR SHALL give bitwise a op b; C=cin; V=0.
REQ-021 mode 00101 ASL SHALL give out={a[6:0],0}, C=a7; mode 00110 LSR SHALL give out={0,a[7:1]}, C=a0; V=0.
REQ-022 mode 00111 ROL SHALL give out={a[6:0],cin}, C=a7; mode 01000 ROR SHALL give out={cin,a[7:1]}, C=a0; V=0.
REQ-023 mode 01001 INC SHALL give out=a+1, mode 01010 DEC out=a-1, both mod 256 (0xFF->0x00, 0x00->0xFF); C=cin; V=0.
REQ-024 mode 01011 CMP SHALL give out=a-b mod 256 ignoring cin; C=(a>=b unsigned); V=0.
REQ-025 mode 01100 PASS_A SHALL give out=a, mode 01101 PASS_B out=b; C=cin; V=0.
REQ-026 mode 01110 BIT SHALL give out=a&b, Z=(a&b)==0, N=b7, V=b6, C=cin.
REQ-027 all other mode codes SHALL give out=0x00, C=cin, V=0, Z=1, N=0.
REQ-028 except BIT, Z SHALL equal (alu_out==0) and N SHALL equal alu_out[7].
REQ-029 no decimal (BCD) mode SHALL exist; arithmetic is binary only.
REQ-030 PC SHALL update on rising clk with priority pc_ld over pc_inc: pc_ld=1 loads pc_in; else pc_inc=1 adds 1; else holds.
REQ-031 PC increment SHALL wrap 16'hFFFF -> 16'h0000 without any flag.
REQ-032 pc_ld and pc_inc both high SHALL load pc_in (no increment that cycle).

Reset
REQ-033 rst high SHALL force pc_out=PC_RESET immediately, independent of clk, and hold it while asserted, overriding pc_ld/pc_inc.
REQ-034 first update after rst deasserts SHALL occur on the next rising clk edge.
REQ-035 ALU outputs SHALL be unaffected by rst (remain combinational functions of inputs).

Verification
REQ-036 ADD a=0x50 b=0x50 cin=0 -> out=0xA0 C=0 V=1 N=1 Z=0; ADD a=0xFF b=0x01 cin=0 -> out=0x00 C=1 V=0 Z=1.
REQ-037 SUB a=0x50 b=0xF0 cin=1 -> out=0x60 C=0 V=0; CMP a=0x10 b=0x10 -> out=0x00 Z=1 C=1; CMP a=0x0F b=0x10 -> out=0xFF C=0 N=1.
REQ-038 ROR a=0x01 cin=1 -> out=0x80 C=1 N=1; ASL a=0x80 -> out=0x00 C=1 Z=1.
REQ-039 BIT a=0x0F b=0xC0 -> Z=1 N=1 V=1; undefined mode 11111 -> out=0x00 Z=1 V=0 C=cin.
REQ-040 PC: rst -> 0x0000; pc_inc 3 cycles -> 0x0003; pc_ld pc_in=0xFFFF with pc_inc -> 0xFFFF; pc_inc -> 0x0000; hold with both low.
REQ-041 PC: rst asserted between clock edges at pc_out=0x1234 -> pc_out=0x0000 before next edge; stays 0x0000 with pc_inc=1 until rst low.
